bottle_crate_counter: RTL
=========================

BOTTLE_CRATE_COUNTER -- requirements
Module: bottle_crate_counter

Interface
REQ-001 SHALL have parameter CRATE_SIZE, default 12, meaning bottles per crate (legal range 2..15).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port enable, input, 1 bit, line-run request from the operator.
REQ-005 SHALL have port bottle_sensor, input, 1 bit, synchronous level from the fill sensor; each rising edge means one filled bottle.
REQ-006 SHALL have port crate_ack, input, 1 bit, meaning a fresh crate is in position.
REQ-007 SHALL have port cork_load, input, 1 bit, load strobe for the cork stock.
REQ-008 SHALL have port cork_value, input, 4 bits, cork stock to load (0..15).
REQ-009 SHALL have port bottle_count, output, 4 bits, bottles in the current crate (0..CRATE_SIZE-1).
REQ-010 SHALL have port crate_count, output, 4 bits, BCD count of completed crates (0..9).
REQ-011 SHALL have port crate_full, output, 1 bit, high while waiting for crate_ack.
REQ-012 SHALL have port crate_ovf, output, 1 bit, one-cycle pulse when crate_count wraps from 9 to 0.
REQ-013 SHALL have port cork_empty, output, 1 bit, high while the cork stock equals 0.
REQ-014 SHALL have port conveyor_run, output, 1 bit, high only in state RUN.
REQ-015 SHALL have port state, output, 2 bits, encoded as IDLE=00, RUN=01, FULL=10, NO_CORK=11.

Function
REQ-016 SHALL register bottle_sensor every cycle into sensor_q; edge = bottle_sensor AND NOT sensor_q.
REQ-017 SHALL count an edge only in RUN with enable=1 and cork_load=0; a counted edge increments bottle_count and decrements cork stock in the same clock.
REQ-018 SHALL register all outputs; a counted edge sampled at clock n SHALL be visible on the outputs after clock n.
REQ-019 SHALL transition IDLE->RUN when enable=1 and stock>0, and IDLE->NO_CORK when enable=1 and stock=0.
REQ-020 SHALL transition RUN->IDLE when enable=0, holding all counts.
REQ-021 SHALL, when a counted edge occurs with bottle_count=CRATE_SIZE-1, set bottle_count to 0, increment crate_count (9 wraps to 0 and pulses crate_ovf), and go to FULL.
REQ-022 SHALL stay in FULL regardless of enable, ignoring edges (sensor_q still tracks), until crate_ack=1, then go to RUN if enable=1, IDLE if enable=0.
REQ-023 SHALL go RUN->NO_CORK in the clock after the stock reaches 0; the filling edge itself is still counted.
REQ-024 SHALL give crate-completion precedence when the last cork fills the last bottle: next state FULL; after crate_ack, go to NO_CORK if stock=0.
REQ-025 SHALL load cork_value into the stock in any state on cork_load=1; load wins over a same-cycle edge, which is discarded.
REQ-026 SHALL transition NO_CORK->RUN (or IDLE if enable=0) the cycle after a nonzero load; a load of 0 keeps NO_CORK.
REQ-027 SHALL perform increments with a 4-bit ripple adder and hold both counters below their wrap values at all times.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, clear state to IDLE and set bottle_count, crate_count, cork stock, and sensor_q to 0.
REQ-029 SHALL drive crate_full=0, crate_ovf=0, conveyor_run=0, and cork_empty=1 after reset.
REQ-030 SHALL let reset override all other inputs, including mid-FULL and a same-cycle cork_load.

Verification
REQ-031 SHALL cover basic fill: load 15 corks, enable=1, 3 sensor pulses -> bottle_count=3, stock=12, state=RUN.
REQ-032 SHALL cover crate completion: 12 pulses -> bottle_count=0, crate_count=1, crate_full=1, conveyor_run=0; 2 further pulses -> no change; crate_ack -> RUN.
REQ-033 SHALL cover BCD wrap: complete 10 crates -> crate_count 9->0 with crate_ovf high for exactly 1 cycle.
REQ-034 SHALL cover cork exhaustion: load 2, then 3 pulses -> bottle_count=2, state=NO_CORK, cork_empty=1; load 5 -> RUN on the next cycle.
REQ-035 SHALL cover simultaneous events: cork_load with a sensor edge -> stock=cork_value, count unchanged; sensor held high for 10 cycles -> counted once.
REQ-036 SHALL cover reset mid-operation: reset in FULL with crate_count=4 -> IDLE, all counts 0, cork_empty=1.

Source files
------------

// File: rtl/bottle_crate_counter.sv
// Bottling-line controller: counts filled bottles into crates, tracks a BCD crate
// tally and the cork stock, and sequences the conveyor through IDLE/RUN/FULL/NO_CORK.
module bottle_crate_counter #(
   parameter int CRATE_SIZE = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       bottle_sensor,
   input  logic       crate_ack,
   input  logic       cork_load,
   input  logic [3:0] cork_value,
   output logic [3:0] bottle_count,
   output logic [3:0] crate_count,
   output logic       crate_full,
   output logic       crate_ovf,
   output logic       cork_empty,
   output logic       conveyor_run,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUN     = 2'b01,
      FULL    = 2'b10,
      NO_CORK = 2'b11
   } state_t;

   localparam logic [3:0] LAST_BOTTLE = 4'(CRATE_SIZE - 1);

   // 4-bit ripple-carry adder; adding 4'hF gives a decrement.
   function automatic logic [3:0] rca4(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] s;
      logic       c;
      c = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      return s;
   endfunction

   state_t     state_q, state_d;
   logic [3:0] bottle_q, bottle_d;
   logic [3:0] crate_q, crate_d;
   logic [3:0] stock_q, stock_d;
   logic       sensor_q;
   logic       ovf_q, ovf_d;
   logic       full_q, run_q, empty_q;
   logic       edge_det, counted, last;

   always_comb begin
      state_d  = state_q;
      bottle_d = bottle_q;
      crate_d  = crate_q;
      stock_d  = stock_q;
      ovf_d    = 1'b0;

      edge_det = bottle_sensor & ~sensor_q;
      // The stock guard covers the single RUN cycle after the last cork is used.
      counted  = (state_q == RUN) & enable & ~cork_load & edge_det & (stock_q != 4'd0);
      last     = (bottle_q == LAST_BOTTLE);

      if (cork_load)
         stock_d = cork_value;
      else if (counted)
         stock_d = rca4(stock_q, 4'hF);

      if (counted) begin
         if (last) begin
            bottle_d = 4'd0;
            if (crate_q == 4'd9) begin
               crate_d = 4'd0;
               ovf_d   = 1'b1;
            end else begin
               crate_d = rca4(crate_q, 4'd1);
            end
         end else begin
            bottle_d = rca4(bottle_q, 4'd1);
         end
      end

      unique case (state_q)
         IDLE:
            if (enable) state_d = (stock_q != 4'd0) ? RUN : NO_CORK;
         RUN:
            if (counted && last)       state_d = FULL;
            else if (!enable)          state_d = IDLE;
            else if (stock_q == 4'd0)  state_d = NO_CORK;
         FULL:
            if (crate_ack) begin
               if (stock_q == 4'd0) state_d = NO_CORK;
               else                 state_d = enable ? RUN : IDLE;
            end
         NO_CORK:
            if (stock_q != 4'd0) state_d = enable ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         bottle_q <= 4'd0;
         crate_q  <= 4'd0;
         stock_q  <= 4'd0;
         sensor_q <= 1'b0;
         ovf_q    <= 1'b0;
         full_q   <= 1'b0;
         run_q    <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         bottle_q <= bottle_d;
         crate_q  <= crate_d;
         stock_q  <= stock_d;
         sensor_q <= bottle_sensor;
         ovf_q    <= ovf_d;
         full_q   <= (state_d == FULL);
         run_q    <= (state_d == RUN);
         empty_q  <= (stock_d == 4'd0);
      end
   end

   assign bottle_count = bottle_q;
   assign crate_count  = crate_q;
   assign crate_full   = full_q;
   assign crate_ovf    = ovf_q;
   assign cork_empty   = empty_q;
   assign conveyor_run = run_q;
   assign state        = state_q;

endmodule
